ssd_score_ctrl: RTL and testbench



---
 rtl/ssd_score_ctrl_if.sv | 14 +
 rtl/ssd_score_ctrl.sv | 99 +++++++++
 tb/tb_ssd_score_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ssd_score_ctrl_if.sv
// Score display bus: load handshake from the game FSM plus the shared
// seven-segment anode/cathode pins.
interface ssd_score_ctrl_if;
  logic [15:0] value;
  logic        load;
  logic        blank;
  logic        busy;
  logic        ovf;
  logic [7:0]  An;
  logic [7:0]  Cath;

  modport master (output value, load, blank, input busy, ovf, An, Cath);
  modport slave  (input value, load, blank, output busy, ovf, An, Cath);
endinterface

// File: rtl/ssd_score_ctrl.sv
// Score-to-BCD converter (sequential double dabble) and 4-digit seven-segment scanner.
// Define SSD_LZB_EN to blank leading zeros on digits 3..1.
module ssd_score_ctrl #(
  parameter int SCAN_BITS = 18
) (
  input  logic Clk,
  input  logic Reset,
  ssd_score_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                 state;
  logic [15:0]            bin;
  logic [19:0]            bcd;
  logic [19:0]            bcd_adj;
  logic [4:0]             iter;
  logic [15:0]            disp;
  logic                   ovf_q;
  logic [SCAN_BITS+1:0]   pre;
  logic [1:0]             dig;
  logic [3:0]             nib;
  logic [7:0]             seg;

  // Add-3 correction on every nibble before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      bin   <= '0;
      bcd   <= '0;
      iter  <= '0;
      disp  <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.load) begin
          bin   <= bus.value;
          bcd   <= '0;
          iter  <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj[18:0], bin, 1'b0};
          iter       <= iter + 5'd1;
          if (iter == 5'd15) state <= COMMIT;
        end
        COMMIT: begin
          // Anything past 9999 saturates so the display never wraps.
          if (bcd[19:16] != 4'd0) begin
            disp  <= 16'h9999;
            ovf_q <= 1'b1;
          end else begin
            disp  <= bcd[15:0];
            ovf_q <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) pre <= '0;
    else       pre <= pre + 1'b1;
  end

  assign dig = pre[SCAN_BITS+1:SCAN_BITS];
  assign nib = disp[{dig, 2'b00} +: 4];

  always_comb begin
    case (nib)
      4'd0: seg = 8'b00000011;
      4'd1: seg = 8'b10011111;
      4'd2: seg = 8'b00100101;
      4'd3: seg = 8'b00001101;
      4'd4: seg = 8'b10011001;
      4'd5: seg = 8'b01001001;
      4'd6: seg = 8'b01000001;
      4'd7: seg = 8'b00011111;
      4'd8: seg = 8'b00000001;
      4'd9: seg = 8'b00001001;
      default: seg = 8'hFF;
    endcase
`ifdef SSD_LZB_EN
    if (dig != 2'd0 && (disp >> {dig, 2'b00}) == 16'd0) seg = 8'hFF;
`endif
  end

  assign bus.busy = (state != IDLE);
  assign bus.ovf  = ovf_q;
  assign bus.An   = bus.blank ? 8'hFF : ~(8'd1 << dig);
  assign bus.Cath = seg;
endmodule

// File: tb/tb_ssd_score_ctrl.sv
// Directed bench for ssd_score_ctrl with SCAN_BITS=2 (digit advances every 4 clocks).
module tb_ssd_score_ctrl;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] cnt;

  ssd_score_ctrl_if bus();
  ssd_score_ctrl #(.SCAN_BITS(2)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  // Independent model of the free-running scan prescaler.
  always @(posedge Clk or posedge Reset)
    if (Reset) cnt <= '0;
    else       cnt <= cnt + 4'd1;

  typedef struct {
    logic [15:0] value;
    logic [15:0] disp;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] segf(input logic [3:0] n);
    case (n)
      4'd0: return 8'b00000011;
      4'd1: return 8'b10011111;
      4'd2: return 8'b00100101;
      4'd3: return 8'b00001101;
      4'd4: return 8'b10011001;
      4'd5: return 8'b01001001;
      4'd6: return 8'b01000001;
      4'd7: return 8'b00011111;
      4'd8: return 8'b00000001;
      4'd9: return 8'b00001001;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] exp_cath(input logic [15:0] disp, input int d);
    logic [15:0] sh;
    logic [7:0] c;
    sh = disp >> (4 * d);
    c = segf(sh[3:0]);
`ifdef SSD_LZB_EN
    if (d != 0 && sh == 16'd0) c = 8'hFF;
`endif
    return c;
  endfunction

  // One full scan period; call at a negedge.
  task automatic check_scan(input logic [15:0] disp);
    int d;
    for (int i = 0; i < 16; i++) begin
      d = int'(cnt[3:2]);
      chk("scan_an", {24'd0, bus.An}, {24'd0, ~(8'd1 << d)});
      chk("scan_cath", {24'd0, bus.Cath}, {24'd0, exp_cath(disp, d)});
      @(negedge Clk);
    end
  endtask

  // Load, count busy cycles (second load injected after `late` busy cycles if late>0).
  task automatic do_load(input logic [15:0] v, input int late, input logic [15:0] v2, output int nb);
    bus.value = v; bus.load = 1'b1;
    @(negedge Clk);
    bus.load = 1'b0;
    nb = 0;
    while (bus.busy && nb < 40) begin
      nb++;
      if (late > 0 && nb == late) begin bus.value = v2; bus.load = 1'b1; end
      else bus.load = 1'b0;
      @(negedge Clk);
    end
    bus.load = 1'b0;
  endtask

  initial begin
    int nb;
    vecs[0] = '{16'd1234,  16'h1234, 1'b0};
    vecs[1] = '{16'd65535, 16'h9999, 1'b1};
    vecs[2] = '{16'd7,     16'h0007, 1'b0};
    vecs[3] = '{16'd42,    16'h0042, 1'b0};
    vecs[4] = '{16'd0,     16'h0000, 1'b0};
    vecs[5] = '{16'd9999,  16'h9999, 1'b0};
    vecs[6] = '{16'd10000, 16'h9999, 1'b1};
    vecs[7] = '{16'd100,   16'h0100, 1'b0};

    bus.value = '0; bus.load = 1'b0; bus.blank = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_ovf",  {31'd0, bus.ovf}, 32'd0);
    chk("rst_an",   {24'd0, bus.An}, 32'hFE);
    chk("rst_cath", {24'd0, bus.Cath}, 32'h03);
    Reset = 1'b0;
    @(negedge Clk);
    check_scan(16'h0000);

    for (int i = 0; i < 8; i++) begin
      do_load(vecs[i].value, 0, 16'd0, nb);
      chk("busy_cycles", nb, 17);
      chk("ovf", {31'd0, bus.ovf}, {31'd0, vecs[i].ovf});
      check_scan(vecs[i].disp);
    end

    // Load while busy is dropped; timing and result unchanged.
    do_load(16'd1234, 5, 16'd5678, nb);
    chk("ign_busy_cycles", nb, 17);
    chk("ign_ovf", {31'd0, bus.ovf}, 32'd0);
    check_scan(16'h1234);

    // Back-to-back: load accepted on the cycle busy falls.
    do_load(16'd65535, 0, 16'd0, nb);
    do_load(16'd7, 0, 16'd0, nb);
    chk("b2b_busy_cycles", nb, 17);
    chk("b2b_ovf", {31'd0, bus.ovf}, 32'd0);
    check_scan(16'h0007);

    // Reset in the 8th SHIFT cycle discards the conversion.
    bus.value = 16'd9999; bus.load = 1'b1;
    @(negedge Clk);
    bus.load = 1'b0;
    repeat (7) @(negedge Clk);
    chk("mid_busy_pre", {31'd0, bus.busy}, 32'd1);
    Reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_ovf",  {31'd0, bus.ovf}, 32'd0);
    chk("mid_rst_an",   {24'd0, bus.An}, 32'hFE);
    chk("mid_rst_cath", {24'd0, bus.Cath}, 32'h03);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (20) @(negedge Clk);
    chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
    check_scan(16'h0000);

    // Blanking: anodes off, prescaler undisturbed.
    do_load(16'd1234, 0, 16'd0, nb);
    bus.blank = 1'b1;
    #1;
    chk("blank_immediate", {24'd0, bus.An}, 32'hFF);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      chk("blank_an", {24'd0, bus.An}, 32'hFF);
    end
    bus.blank = 1'b0;
    #1;
    check_scan(16'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
